pipe_mem_stage: RTL and testbench

- Memory-access stage. Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB write-back path.
- Consumes the latched execute results: ALU result/address, store data, write-enables and destination register.
- Performs loads and stores over a req/ack data-memory handshake. Stalls upstream while an access is outstanding.
- Presents registered write-back data, enable and destination register.

---
 rtl/pipe_mem_stage.sv | 159 +++++++++++++++
 tb/tb_pipe_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// Memory-access stage: 1-cycle pass-through for ALU ops, req/ack load/store with upstream stall.
// Optional BOUNDS_CHECK_EN macro suppresses out-of-range accesses and raises a sticky mem_err.
module pipe_mem_stage #(
  parameter int DATAPATH_WIDTH = 64,
  parameter int REGFILE_ADDR   = 3,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_MEM_START = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      WRegEn_in,
  input  logic                      WMemEn_in,
  input  logic                      RMemEn_in,
  input  logic [DATAPATH_WIDTH-1:0] R1out_in,
  input  logic [DATAPATH_WIDTH-1:0] R2out_in,
  input  logic [REGFILE_ADDR-1:0]   WReg1_in,
  output logic                      stall_out,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATAPATH_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATAPATH_WIDTH-1:0] mem_rdata,
  output logic                      WRegEn_out,
  output logic [REGFILE_ADDR-1:0]   WReg1_out,
  output logic [DATAPATH_WIDTH-1:0] WData_out,
  output logic                      mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_q, state_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAPATH_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                      lat_en_q, lat_en_d;
  logic [REGFILE_ADDR-1:0]   lat_reg_q, lat_reg_d;
  logic [DATAPATH_WIDTH-1:0] lat_r1_q, lat_r1_d;
  logic                      is_load_q, is_load_d;
  logic                      wb_en_q, wb_en_d;
  logic [REGFILE_ADDR-1:0]   wb_reg_q, wb_reg_d;
  logic [DATAPATH_WIDTH-1:0] wb_dat_q, wb_dat_d;

  logic access, oob, issue;

  assign access = WMemEn_in | RMemEn_in;
  assign issue  = access & ~oob;

`ifdef BOUNDS_CHECK_EN
  localparam logic [MEM_ADDR_WIDTH-1:0] START_ADDR = MEM_ADDR_WIDTH'(DATA_MEM_START);

  logic mem_err_q;

  assign oob = (R1out_in[MEM_ADDR_WIDTH-1:0] < START_ADDR) |
               (|R1out_in[DATAPATH_WIDTH-1:MEM_ADDR_WIDTH]);

  always_ff @(posedge clk) begin
    if (!reset)
      mem_err_q <= 1'b0;
    else if ((state_q == IDLE) && access && oob)
      mem_err_q <= 1'b1;
  end

  assign mem_err = mem_err_q;
`else
  assign oob     = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign stall_out = ((state_q == IDLE) & issue) | ((state_q == BUSY) & ~mem_ack);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_en_d    = lat_en_q;
    lat_reg_d   = lat_reg_q;
    lat_r1_d    = lat_r1_q;
    is_load_d   = is_load_q;
    wb_en_d     = wb_en_q;
    wb_reg_d    = wb_reg_q;
    wb_dat_d    = wb_dat_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = WMemEn_in;
          mem_addr_d  = R1out_in[MEM_ADDR_WIDTH-1:0];
          mem_wdata_d = R2out_in;
          lat_en_d    = WRegEn_in;
          lat_reg_d   = WReg1_in;
          lat_r1_d    = R1out_in;
          is_load_d   = ~WMemEn_in;
          wb_en_d     = 1'b0;
        end else begin
          // A suppressed (out-of-range) access still flows through, but never writes back.
          wb_en_d  = WRegEn_in & ~access;
          wb_reg_d = WReg1_in;
          wb_dat_d = R1out_in;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          wb_en_d   = lat_en_q;
          wb_reg_d  = lat_reg_q;
          wb_dat_d  = is_load_q ? mem_rdata : lat_r1_q;
        end else begin
          wb_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_en_q    <= 1'b0;
      lat_reg_q   <= '0;
      lat_r1_q    <= '0;
      is_load_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_en_q    <= lat_en_d;
      lat_reg_q   <= lat_reg_d;
      lat_r1_q    <= lat_r1_d;
      is_load_q   <= is_load_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_dat_q    <= wb_dat_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign WRegEn_out = wb_en_q;
  assign WReg1_out  = wb_reg_q;
  assign WData_out  = wb_dat_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage: expected write-backs are queued at issue and
// checked by a negedge monitor; stall/mem_* interface values are checked inline.
module tb_pipe_mem_stage;

  logic        clk;
  logic        reset;
  logic        WRegEn_in, WMemEn_in, RMemEn_in;
  logic [63:0] R1out_in, R2out_in;
  logic [2:0]  WReg1_in;
  logic        stall_out, mem_req, mem_we, mem_ack, mem_err;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        WRegEn_out;
  logic [2:0]  WReg1_out;
  logic [63:0] WData_out;

  typedef struct {
    logic [2:0]  rd;
    logic [63:0] data;
  } wb_t;

  wb_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  pulses = 0;
  logic req_prev = 1'b0;

  pipe_mem_stage dut (
    .clk(clk), .reset(reset),
    .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in), .RMemEn_in(RMemEn_in),
    .R1out_in(R1out_in), .R2out_in(R2out_in), .WReg1_in(WReg1_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .WRegEn_out(WRegEn_out), .WReg1_out(WReg1_out), .WData_out(WData_out),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] rd, input logic [63:0] data);
    wb_t e;
    e.rd = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    WRegEn_in = 1'b0; WMemEn_in = 1'b0; RMemEn_in = 1'b0;
    R1out_in = '0; R2out_in = '0; WReg1_in = '0;
  endtask

  // Monitor: every presented write-back must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_req && !req_prev) pulses++;
    req_prev = mem_req;
    if (reset && WRegEn_out) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 64'(WReg1_out), 64'hFF);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wb_reg", 64'(WReg1_out), 64'(e.rd));
        check("wb_data", WData_out, e.data);
      end
    end
  end

  initial begin
    idle_inputs();
    mem_ack = 1'b0;
    mem_rdata = '0;

    // Reset held with a load pending: nothing may issue.
    reset = 1'b0;
    WRegEn_in = 1'b1; RMemEn_in = 1'b1; R1out_in = 64'd600; WReg1_in = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mem_req", 64'(mem_req), 64'd0);
    end
    check("rst_wren", 64'(WRegEn_out), 64'd0);
    check("rst_wdata", WData_out, 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rel_stall", 64'(stall_out), 64'd0);
    tick();

    // ALU pass-through.
    WRegEn_in = 1'b1; WReg1_in = 3'd5; R1out_in = 64'h1234;
    push(3'd5, 64'h1234);
    #1;
    check("alu_stall", 64'(stall_out), 64'd0);
    tick();
    idle_inputs();
    tick();

    // Load with three BUSY cycles before ack.
    WRegEn_in = 1'b1; RMemEn_in = 1'b1; R1out_in = 64'd600; WReg1_in = 3'd2;
    push(3'd2, 64'hDEADBEEF);
    #1;
    check("ld_stall0", 64'(stall_out), 64'd1);
    tick();
    check("ld_req", 64'(mem_req), 64'd1);
    check("ld_addr", 64'(mem_addr), 64'd600);
    check("ld_we", 64'(mem_we), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("ld_stall_busy", 64'(stall_out), 64'd1);
      if (i < 2) tick();
    end
    mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
    #1;
    check("ld_stall_ack", 64'(stall_out), 64'd0);
    idle_inputs();
    tick();
    mem_ack = 1'b0;
    check("ld_req_drop", 64'(mem_req), 64'd0);
    tick();

    // Store with same-cycle ack, then a back-to-back load.
    WRegEn_in = 1'b1; WMemEn_in = 1'b1; R1out_in = 64'd700; R2out_in = 64'hAA; WReg1_in = 3'd3;
    push(3'd3, 64'd700);
    #1;
    check("st_stall0", 64'(stall_out), 64'd1);
    tick();
    check("st_we", 64'(mem_we), 64'd1);
    check("st_wdata", mem_wdata, 64'hAA);
    check("st_addr", 64'(mem_addr), 64'd700);
    mem_ack = 1'b1;
    WMemEn_in = 1'b0; RMemEn_in = 1'b1; R1out_in = 64'd800; R2out_in = '0; WReg1_in = 3'd4;
    push(3'd4, 64'h55);
    #1;
    check("st_stall_ack", 64'(stall_out), 64'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("b2b_req_low", 64'(mem_req), 64'd0);
    check("b2b_stall", 64'(stall_out), 64'd1);
    tick();
    check("b2b_req", 64'(mem_req), 64'd1);
    check("b2b_addr", 64'(mem_addr), 64'd800);
    check("b2b_we", 64'(mem_we), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h55;
    idle_inputs();
    tick();
    mem_ack = 1'b0;
    tick();

    // Reset while BUSY: the access is abandoned and a late ack is ignored.
    WRegEn_in = 1'b1; RMemEn_in = 1'b1; R1out_in = 64'd900; WReg1_in = 3'd6;
    tick();
    check("ab_req", 64'(mem_req), 64'd1);
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("ab_req_low", 64'(mem_req), 64'd0);
    check("ab_stall", 64'(stall_out), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h77;
    tick();
    mem_ack = 1'b0;
    check("ab_req_idle", 64'(mem_req), 64'd0);
    tick();
    check("ab_no_wb", 64'(WRegEn_out), 64'd0);

    // Load to an address below the data region.
    WRegEn_in = 1'b1; RMemEn_in = 1'b1; R1out_in = 64'd100; WReg1_in = 3'd7;
`ifdef BOUNDS_CHECK_EN
    #1;
    check("oob_stall", 64'(stall_out), 64'd0);
    tick();
    check("oob_req", 64'(mem_req), 64'd0);
    check("oob_wren", 64'(WRegEn_out), 64'd0);
    check("oob_err", 64'(mem_err), 64'd1);
    idle_inputs();
    tick();
    tick();
    check("oob_err_sticky", 64'(mem_err), 64'd1);
`else
    push(3'd7, 64'h99);
    #1;
    check("lo_stall", 64'(stall_out), 64'd1);
    tick();
    check("lo_req", 64'(mem_req), 64'd1);
    check("lo_addr", 64'(mem_addr), 64'd100);
    idle_inputs();
    mem_ack = 1'b1; mem_rdata = 64'h99;
    tick();
    mem_ack = 1'b0;
    tick();
    check("lo_err", 64'(mem_err), 64'd0);
`endif

    tick();
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
`ifdef BOUNDS_CHECK_EN
    check("req_pulses", 64'(pulses), 64'd4);
`else
    check("req_pulses", 64'(pulses), 64'd5);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
